lcd_init_sequencer: RTL and testbench

//  Sequences the ST7789V3 panel bring-up: hardware reset pulse, then a ROM table
//  of command/data/delay entries. Each byte goes to the downstream SPI byte

---
 rtl/lcd_init_sequencer.sv | 153 +++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - ST7789V3 bring-up sequencer: reset pulse, then ROM-driven cmd/data/delay stream
// Bytes leave over a valid/ready handshake toward the SPI byte transmitter.
module lcd_init_sequencer #(
  parameter int AW           = 5,
  parameter int RST_LOW_CYC  = 34000,
  parameter int RST_WAIT_CYC = 408000,
  parameter int MS_CYC       = 3400
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [9:0]    rom_data,
  output logic          tx_valid,
  output logic [7:0]    tx_byte,
  output logic          tx_dc,
  input  logic          tx_ready,
  output logic          lcd_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DLY_MAX  = 255 * MS_CYC;
  localparam int CNT_MAX0 = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > DLY_MAX) ? CNT_MAX0 : DLY_MAX;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    IDLE, RST_LO, RST_WAIT, FETCH, DECODE, SEND, DELAY, NEXT, DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_n;
  logic          valid_n, dc_n, lcd_rst_n, busy_n, done_n, err_n;
  logic [7:0]    byte_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rom_addr <= '0;
      tx_valid <= 1'b0;
      tx_byte  <= 8'h00;
      tx_dc    <= 1'b0;
      lcd_rst  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rom_addr <= addr_n;
      tx_valid <= valid_n;
      tx_byte  <= byte_n;
      tx_dc    <= dc_n;
      lcd_rst  <= lcd_rst_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = rom_addr;
    valid_n   = tx_valid;
    byte_n    = tx_byte;
    dc_n      = tx_dc;
    lcd_rst_n = lcd_rst;
    busy_n    = busy;
    done_n    = done;
    err_n     = err;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = RST_LO;
          cnt_n     = CW'(RST_LOW_CYC - 1);
          addr_n    = '0;
          lcd_rst_n = 1'b0;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          err_n     = 1'b0;
        end
      end
      RST_LO: begin
        if (cnt == '0) begin
          lcd_rst_n = 1'b1;
          state_n   = RST_WAIT;
          cnt_n     = CW'(RST_WAIT_CYC - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RST_WAIT: begin
        if (cnt == '0) state_n = FETCH;
        else           cnt_n   = cnt - CW'(1);
      end
      FETCH: state_n = DECODE;
      // rom_data now reflects rom_addr presented during FETCH
      DECODE: begin
        unique case (rom_data[9:8])
          2'b00, 2'b01: begin
            byte_n  = rom_data[7:0];
            dc_n    = rom_data[8];
            valid_n = 1'b1;
            state_n = SEND;
          end
          2'b10: begin
            if (rom_data[7:0] == 8'h00) begin
              state_n = NEXT;
            end else begin
              cnt_n   = CW'(rom_data[7:0]) * CW'(MS_CYC);
              state_n = DELAY;
            end
          end
          default: begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        endcase
      end
      SEND: begin
        if (tx_ready) begin
          valid_n = 1'b0;
          state_n = NEXT;
        end
      end
      DELAY: begin
        if (cnt == CW'(1)) state_n = NEXT;
        cnt_n = cnt - CW'(1);
      end
      NEXT: begin
        // Running past the last entry without an end marker is a table fault
        if (rom_addr == ADDR_LAST) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          addr_n  = rom_addr + AW'(1);
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb/tb_lcd_init_sequencer.sv - bench for lcd_init_sequencer: directed and random tables vs timing/transfer model
module tb_lcd_init_sequencer;

  localparam int AW = 3;
  localparam int RL = 4;
  localparam int RW = 8;
  localparam int MS = 2;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [9:0]    rom_data = 10'h0;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_dc;
  logic          tx_ready;
  logic          lcd_rst;
  logic          busy;
  logic          done;
  logic          err;

  lcd_init_sequencer #(.AW(AW), .RST_LOW_CYC(RL), .RST_WAIT_CYC(RW), .MS_CYC(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_dc(tx_dc), .tx_ready(tx_ready),
    .lcd_rst(lcd_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int stall7_cnt = 0;
  int stall_cycles = 0;
  logic [9:0] rom [0:(1<<AW)-1];
  logic [8:0] xfer_q[$];
  int         xfer_t[$];
  logic [8:0] exp_q[$];
  int         exp_t[$];
  int         exp_done_t, exp_addr;
  logic       exp_err;
  logic       pv = 1'b0, pr = 1'b0, pd = 1'b0;
  logic [7:0] pb = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr)
        check("hold_stable", 32'({tx_valid, tx_byte, tx_dc}), 32'({1'b1, pb, pd}));
      if (tx_valid && tx_ready) begin
        xfer_q.push_back({tx_byte, tx_dc});
        xfer_t.push_back(cyc);
      end
      if (tx_valid && !tx_ready) stall_cycles++;
    end
    pv = tx_valid && !rst;
    pr = tx_ready;
    pb = tx_byte;
    pd = tx_dc;
  end

  // Ready is decided just after each rising edge from the freshly registered tx_valid.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: tx_ready = 1'($urandom_range(0, 1));
        2: begin
          if (tx_valid && tx_byte == 8'h55 && stall7_cnt < 7) begin
            tx_ready = 1'b0;
            stall7_cnt++;
          end else tx_ready = 1'b1;
        end
        3: tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Expected transfers and timing, in cycles after the accepting start edge.
  task automatic model_run();
    int t;
    exp_q.delete();
    exp_t.delete();
    t = RL + RW;
    for (int i = 0; i < (1 << AW); i++) begin
      logic [1:0] ty;
      logic [7:0] p;
      ty = rom[i][9:8];
      p  = rom[i][7:0];
      if (ty == 2'b11) begin
        exp_err = 1'b0;
        exp_addr = i;
        exp_done_t = t + 2;
        return;
      end else if (ty == 2'b10) begin
        t += 3 + int'(p) * MS;
      end else begin
        exp_q.push_back({p, ty[0]});
        exp_t.push_back(t + 2);
        t += 4;
      end
    end
    exp_err = 1'b1;
    exp_addr = (1 << AW) - 1;
    exp_done_t = t;
  endtask

  task automatic run_seq(input string tag, input bit poke);
    int idx, low, c0;
    bit poked;
    xfer_q.delete();
    xfer_t.delete();
    stall_cycles = 0;
    stall7_cnt = 0;
    model_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    idx = 0;
    low = lcd_rst ? 0 : 1;
    poked = 0;
    check({tag, "_busy_on_start"}, 32'({busy, done, err}), 32'(3'b100));
    while (!done && idx < BUDGET) begin
      if (poke && !poked && tx_valid) begin
        start = 1'b1;
        poked = 1;
      end
      @(negedge clk);
      start = 1'b0;
      idx++;
      if (!lcd_rst) low++;
    end
    check({tag, "_done_in_budget"}, 32'(idx < BUDGET), 32'(1));
    check({tag, "_rst_low_cycles"}, 32'(low), 32'(RL));
    check({tag, "_done_time"}, 32'(idx), 32'(exp_done_t + stall_cycles));
    check({tag, "_final_flags"}, 32'({busy, done, err, lcd_rst}), 32'({1'b0, 1'b1, exp_err, 1'b1}));
    check({tag, "_final_addr"}, 32'(rom_addr), 32'(exp_addr));
    check({tag, "_xfer_count"}, 32'(xfer_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < xfer_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_xfer_byte_dc"}, 32'(xfer_q[i]), 32'(exp_q[i]));
      if (ready_mode == 0) check({tag, "_xfer_time"}, 32'(xfer_t[i] - c0), 32'(exp_t[i]));
    end
  endtask

  task automatic load_table(input logic [9:0] tbl [0:(1<<AW)-1]);
    for (int i = 0; i < (1 << AW); i++) rom[i] = tbl[i];
  endtask

  initial begin
    logic [9:0] t2 [0:(1<<AW)-1];
    logic [9:0] t5 [0:(1<<AW)-1];
    logic [9:0] t6 [0:(1<<AW)-1];
    logic seen_valid;
    int idx;
    t2 = '{10'h011, 10'h205, 10'h03A, 10'h155, 10'h029, 10'h300, 10'h000, 10'h000};
    t5 = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008};
    t6 = '{10'h214, 10'h300, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    load_table(t2);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", 32'({rom_addr, tx_valid, tx_byte, tx_dc, lcd_rst, busy, done, err}), 32'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen_valid |= tx_valid;
    end
    check("idle_no_valid", 32'(seen_valid), 32'(0));
    check("idle_lcd_rst_busy", 32'({lcd_rst, busy}), 32'(0));

    ready_mode = 0;
    run_seq("table2", 0);
    check("table2_delay_gap", 32'(xfer_t[1] - xfer_t[0]), 32'(17));
    run_seq("table2_rerun", 1);

    ready_mode = 2;
    run_seq("stall55", 0);
    check("stall55_cycles", 32'(stall_cycles), 32'(7));

    ready_mode = 0;
    load_table(t5);
    run_seq("no_end", 0);
    repeat (5) @(negedge clk);
    check("no_end_addr_held", 32'({rom_addr, err, done}), 32'({3'd7, 1'b1, 1'b1}));

    load_table(t6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_delay", 32'({lcd_rst, tx_valid, busy, done, err, rom_addr}), 32'(0));
    repeat (20) @(negedge clk);
    check("rst_in_delay_stays_idle", 32'({lcd_rst, busy, done}), 32'(0));

    load_table(t2);
    ready_mode = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    while (!tx_valid && idx < BUDGET) begin
      @(negedge clk);
      idx++;
    end
    check("send_reached", 32'({tx_valid, tx_byte}), 32'({1'b1, 8'h11}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_send_drops_valid", 32'({tx_valid, tx_byte, tx_dc, busy}), 32'(0));
    ready_mode = 0;
    @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < (1 << AW); i++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 4)      rom[i] = {2'b00, 8'($urandom_range(0, 255))};
        else if (k < 6) rom[i] = {2'b01, 8'($urandom_range(0, 255))};
        else if (k < 8) rom[i] = {2'b10, 8'($urandom_range(0, 3))};
        else            rom[i] = {2'b11, 8'($urandom_range(0, 255))};
      end
      ready_mode = $urandom_range(0, 1);
      run_seq("random", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
